// File: rtl/aer_map_event_scheduler.sv
// Round-robin AER arbiter feeding the local-receptive-field mapper.
// Captures source events into a small FIFO and replays them over a timed 4-phase handshake.
module aer_map_event_scheduler #(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned AER_WIDTH  = 12,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_SRC-1:0]                  SRC_REQ,
  input  logic [N_SRC*AER_WIDTH-1:0]        SRC_EVENT,
  input  logic [N_SRC*(AER_WIDTH-2)-1:0]    SRC_IDX,
  output logic [N_SRC-1:0]                  SRC_ACK,
  output logic                              MAP_IN_AERIN_REQ,
  output logic [AER_WIDTH-1:0]              MAP_IN_AERIN_EVENT,
  output logic [AER_WIDTH-3:0]              MAP_IN_AERIN_IDX,
  input  logic                              MAP_IN_AERIN_ACK,
  input  logic                              ERR_CLR,
  output logic                              ERR_TIMEOUT,
  output logic [$clog2(FIFO_DEPTH):0]       FIFO_LEVEL,
  output logic [CNT_W-1:0]                  DROP_CNT,
  output logic                              BUSY
);

  localparam int unsigned IW = AER_WIDTH - 2;
  localparam int unsigned DW = AER_WIDTH + IW;
  localparam int unsigned SW = $clog2(N_SRC);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic {InIdle, InAck} in_state_e;
  typedef enum logic [1:0] {OutIdle, OutReq, OutRel} out_state_e;

  in_state_e          in_state_q, in_state_d;
  out_state_e         out_state_q, out_state_d;
  logic [N_SRC-1:0]   ack_q, ack_d;
  logic [SW-1:0]      gnt_q, gnt_d;
  logic [SW-1:0]      rr_q, rr_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               req_q, req_d;
  logic [DW-1:0]      data_q, data_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               discarded_q, discarded_d;
  logic               err_q, err_d;
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [LW-1:0]      count_q, count_d;
  logic [DW-1:0]      mem [FIFO_DEPTH];

  logic [AER_WIDTH-1:0] src_evt [N_SRC];
  logic [IW-1:0]        src_idx [N_SRC];
  logic                 gnt_valid;
  logic [SW-1:0]        gnt_idx;
  logic                 push, pop, err_set;
  logic                 fifo_full, fifo_empty;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign src_evt[g] = SRC_EVENT[g*AER_WIDTH +: AER_WIDTH];
    assign src_idx[g] = SRC_IDX[g*IW +: IW];
  end

  function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base, input int unsigned off);
    return SW'((32'(base) + off) % N_SRC);
  endfunction

  assign fifo_full  = (count_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (!gnt_valid && SRC_REQ[rr_idx(rr_q, i)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rr_idx(rr_q, i);
      end
    end
  end

  always_comb begin
    in_state_d = in_state_q;
    ack_d      = ack_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    drop_d     = drop_q;
    push       = 1'b0;
    unique case (in_state_q)
      InIdle: begin
        if (gnt_valid && !fifo_full) begin
          ack_d          = '0;
          ack_d[gnt_idx] = 1'b1;
          gnt_d          = gnt_idx;
          rr_d           = (gnt_idx == SW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
          in_state_d     = InAck;
          // Invalid events still complete the handshake but never reach the mapper.
          if (src_evt[gnt_idx][AER_WIDTH-1 -: 2] == 2'b11) begin
            if (drop_q != '1) drop_d = drop_q + 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      InAck: begin
        if (!SRC_REQ[gnt_q]) begin
          ack_d      = '0;
          in_state_d = InIdle;
        end
      end
      default: in_state_d = InIdle;
    endcase
  end

  always_comb begin
    out_state_d = out_state_q;
    req_d       = req_q;
    data_d      = data_q;
    timer_d     = timer_q;
    discarded_d = discarded_q;
    pop         = 1'b0;
    err_set     = 1'b0;
    unique case (out_state_q)
      OutIdle: begin
        if (!fifo_empty) begin
          req_d       = 1'b1;
          data_d      = mem[rptr_q];
          timer_d     = '0;
          discarded_d = 1'b0;
          out_state_d = OutReq;
        end
      end
      OutReq: begin
        if (MAP_IN_AERIN_ACK) begin
          req_d       = 1'b0;
          out_state_d = OutRel;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          req_d       = 1'b0;
          pop         = 1'b1;
          err_set     = 1'b1;
          discarded_d = 1'b1;
          out_state_d = OutRel;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      OutRel: begin
        if (!MAP_IN_AERIN_ACK) begin
          pop         = !discarded_q;
          out_state_d = OutIdle;
        end
      end
      default: out_state_d = OutIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // A same-cycle set wins over a clear.
  assign err_d = err_set | (err_q & ~ERR_CLR);

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {src_evt[gnt_idx], src_idx[gnt_idx]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state_q  <= InIdle;
      out_state_q <= OutIdle;
      ack_q       <= '0;
      gnt_q       <= '0;
      rr_q        <= '0;
      drop_q      <= '0;
      req_q       <= 1'b0;
      data_q      <= '0;
      timer_q     <= '0;
      discarded_q <= 1'b0;
      err_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      ack_q       <= ack_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      drop_q      <= drop_d;
      req_q       <= req_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      discarded_q <= discarded_d;
      err_q       <= err_d;
      count_q     <= count_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  assign SRC_ACK            = ack_q;
  assign MAP_IN_AERIN_REQ   = req_q;
  assign MAP_IN_AERIN_EVENT = data_q[DW-1 -: AER_WIDTH];
  assign MAP_IN_AERIN_IDX   = data_q[IW-1:0];
  assign ERR_TIMEOUT        = err_q;
  assign FIFO_LEVEL         = count_q;
  assign DROP_CNT           = drop_q;
  assign BUSY               = !fifo_empty || (in_state_q != InIdle) || (out_state_q != OutIdle);

endmodule

// File: tb/tb_aer_map_event_scheduler.sv
// Directed bench for aer_map_event_scheduler: source/mapper models, vector table, corner sequences.
module tb_aer_map_event_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src_req = '0;
  logic [47:0] src_event = '0;
  logic [39:0] src_idx = '0;
  logic [3:0]  SRC_ACK;
  logic        MAP_IN_AERIN_REQ;
  logic [11:0] MAP_IN_AERIN_EVENT;
  logic [9:0]  MAP_IN_AERIN_IDX;
  logic        map_ack = 1'b0;
  logic        ERR_CLR = 1'b0;
  logic        ERR_TIMEOUT;
  logic [3:0]  FIFO_LEVEL;
  logic [15:0] DROP_CNT;
  logic        BUSY;

  aer_map_event_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .SRC_REQ            (src_req),
    .SRC_EVENT          (src_event),
    .SRC_IDX            (src_idx),
    .SRC_ACK            (SRC_ACK),
    .MAP_IN_AERIN_REQ   (MAP_IN_AERIN_REQ),
    .MAP_IN_AERIN_EVENT (MAP_IN_AERIN_EVENT),
    .MAP_IN_AERIN_IDX   (MAP_IN_AERIN_IDX),
    .MAP_IN_AERIN_ACK   (map_ack),
    .ERR_CLR            (ERR_CLR),
    .ERR_TIMEOUT        (ERR_TIMEOUT),
    .FIFO_LEVEL         (FIFO_LEVEL),
    .DROP_CNT           (DROP_CNT),
    .BUSY               (BUSY)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-source pending event rings: main writes src_wr, the driver advances src_rd.
  logic [21:0] src_buf [4][16];
  int          src_wr [4] = '{0, 0, 0, 0};
  int          src_rd [4] = '{0, 0, 0, 0};
  bit          drv_en   = 1'b0;
  bit          map_mode = 1'b1;
  bit          multi_ack = 1'b0;
  logic [21:0] got_q [$];

  // Source model: one 4-phase handshake per pending word.
  initial forever begin
    @(negedge clk);
    if (!drv_en) begin
      src_req = '0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (src_req[s]) begin
          if (SRC_ACK[s]) src_req[s] = 1'b0;
        end else if (!SRC_ACK[s] && src_rd[s] != src_wr[s]) begin
          src_event[s*12 +: 12] = src_buf[s][src_rd[s] % 16][21:10];
          src_idx[s*10 +: 10]   = src_buf[s][src_rd[s] % 16][9:0];
          src_req[s]            = 1'b1;
          src_rd[s]             = src_rd[s] + 1;
        end
      end
    end
  end

  // Mapper model: acks one half-cycle after REQ when enabled, logging each delivered word.
  initial forever begin
    @(negedge clk);
    if (!map_mode) begin
      map_ack = 1'b0;
    end else if (MAP_IN_AERIN_REQ && !map_ack) begin
      map_ack = 1'b1;
      got_q.push_back({MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX});
    end else if (!MAP_IN_AERIN_REQ && map_ack) begin
      map_ack = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if ($countones(SRC_ACK) > 1) multi_ack = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int s, input logic [11:0] ev, input logic [9:0] idx);
    src_buf[s][src_wr[s] % 16] = {ev, idx};
    src_wr[s] = src_wr[s] + 1;
  endtask

  function automatic bit all_idle();
    bit ok;
    ok = (src_req == '0) && (SRC_ACK == '0) && !BUSY;
    for (int s = 0; s < 4; s++) if (src_rd[s] != src_wr[s]) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_idle(input int max, input string name);
    int c = 0;
    while (!all_idle() && c < max) begin
      @(posedge clk); #1;
      c++;
    end
    chk(name, 32'(all_idle()), 32'd1);
  endtask

  task automatic wait_req(input logic val, input int max, output int n);
    n = 0;
    while (MAP_IN_AERIN_REQ !== val && n < max) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    drv_en   = 1'b0;
    map_mode = 1'b1;
    ERR_CLR  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) src_wr[s] = src_rd[s];
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          src;
    logic [11:0] ev;
    logic [9:0]  idx;
    bit          deliver;
    logic [21:0] exp_word;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int base;
    int n;
    logic [21:0] w;

    vecs[0] = '{1, 12'h4A3, 10'h1A3, 1'b1, {12'h4A3, 10'h1A3}, 16'd0};
    vecs[1] = '{2, 12'h8FF, 10'h0FF, 1'b1, {12'h8FF, 10'h0FF}, 16'd0};
    vecs[2] = '{3, 12'hC12, 10'h012, 1'b0, 22'h0,              16'd1};
    vecs[3] = '{0, 12'h7AB, 10'h3AB, 1'b1, {12'h7AB, 10'h3AB}, 16'd1};
    vecs[4] = '{0, 12'h3FF, 10'h3FF, 1'b1, {12'h3FF, 10'h3FF}, 16'd1};
    vecs[5] = '{2, 12'hFFF, 10'h155, 1'b0, 22'h0,              16'd2};
    vecs[6] = '{3, 12'h000, 10'h000, 1'b1, {12'h000, 10'h000}, 16'd2};
    vecs[7] = '{1, 12'hD00, 10'h2AA, 1'b0, 22'h0,              16'd3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_map_req", 32'(MAP_IN_AERIN_REQ), 32'd0);
    chk("rst_src_ack", 32'(SRC_ACK), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_err", 32'(ERR_TIMEOUT), 32'd0);
    chk("rst_drop", 32'(DROP_CNT), 32'd0);
    chk("rst_event", 32'(MAP_IN_AERIN_EVENT), 32'd0);
    chk("rst_idx", 32'(MAP_IN_AERIN_IDX), 32'd0);

    // Single event latency
    drv_en = 1'b1;
    load(0, 12'h005, 10'h005);
    @(negedge clk); #1;
    @(posedge clk); #1;
    chk("t1_src_ack", 32'(SRC_ACK), 32'h1);
    chk("t1_level", 32'(FIFO_LEVEL), 32'd1);
    chk("t1_req_early", 32'(MAP_IN_AERIN_REQ), 32'd0);
    @(posedge clk); #1;
    chk("t1_req", 32'(MAP_IN_AERIN_REQ), 32'd1);
    chk("t1_event", 32'(MAP_IN_AERIN_EVENT), 32'h005);
    chk("t1_idx", 32'(MAP_IN_AERIN_IDX), 32'h005);
    wait_idle(40, "t1_done");
    chk("t1_level_end", 32'(FIFO_LEVEL), 32'd0);
    chk("t1_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("t1_word", 32'(got_q[0]), 32'({12'h005, 10'h005}));

    // Vector table: types 00/01/10 delivered unchanged, 11 dropped and counted
    for (int v = 0; v < 8; v++) begin
      base = got_q.size();
      load(vecs[v].src, vecs[v].ev, vecs[v].idx);
      wait_idle(60, $sformatf("v%0d_done", v));
      chk($sformatf("v%0d_count", v), 32'(got_q.size() - base), 32'(vecs[v].deliver));
      if (vecs[v].deliver && got_q.size() > base)
        chk($sformatf("v%0d_word", v), 32'(got_q[got_q.size()-1]), 32'(vecs[v].exp_word));
      chk($sformatf("v%0d_drop", v), 32'(DROP_CNT), 32'(vecs[v].exp_drop));
      chk($sformatf("v%0d_level", v), 32'(FIFO_LEVEL), 32'd0);
    end

    // All four sources requesting from reset: strict round-robin
    do_reset();
    chk("t2_drop_rst", 32'(DROP_CNT), 32'd0);
    base = got_q.size();
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 4; s++) load(s, 12'(16*s + k + 1), 10'(8*s + k));
    drv_en = 1'b1;
    wait_idle(300, "t2_done");
    chk("t2_count", 32'(got_q.size() - base), 32'd12);
    for (int e = 0; e < 12; e++) begin
      w = {12'(16*(e % 4) + (e / 4) + 1), 10'(8*(e % 4) + (e / 4))};
      if (base + e < got_q.size()) chk($sformatf("t2_order%0d", e), 32'(got_q[base+e]), 32'(w));
    end

    // Mapper stalled: FIFO fills to 8, ninth request waits, nothing lost
    base = got_q.size();
    map_mode = 1'b0;
    for (int k = 0; k < 9; k++) load(0, 12'(12'h100 + k), 10'(k));
    n = 0;
    while (FIFO_LEVEL != 4'd8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("t3_level_full", 32'(FIFO_LEVEL), 32'd8);
    chk("t3_no_ack", 32'(SRC_ACK), 32'd0);
    chk("t3_no_err", 32'(ERR_TIMEOUT), 32'd0);
    map_mode = 1'b1;
    wait_idle(200, "t3_done");
    chk("t3_count", 32'(got_q.size() - base), 32'd9);
    for (int e = 0; e < 9; e++)
      if (base + e < got_q.size())
        chk($sformatf("t3_order%0d", e), 32'(got_q[base+e]), 32'({12'(12'h100 + e), 10'(e)}));

    // Timeout: mapper never acks; two events each time out after exactly 255 cycles
    base = got_q.size();
    map_mode = 1'b0;
    load(0, 12'h0AA, 10'h011);
    load(0, 12'h4BB, 10'h022);
    wait_req(1'b1, 20, n);
    chk("t4_a_event", 32'(MAP_IN_AERIN_EVENT), 32'h0AA);
    wait_req(1'b0, 300, n);
    chk("t4_a_cycles", 32'(n), 32'd255);
    chk("t4_a_err", 32'(ERR_TIMEOUT), 32'd1);
    wait_req(1'b1, 20, n);
    chk("t4_b_event", 32'(MAP_IN_AERIN_EVENT), 32'h4BB);
    chk("t4_b_idx", 32'(MAP_IN_AERIN_IDX), 32'h022);
    chk("t4_err_held", 32'(ERR_TIMEOUT), 32'd1);
    ERR_CLR = 1'b1;
    wait_req(1'b0, 300, n);
    chk("t4_b_cycles", 32'(n), 32'd255);
    chk("t4_set_beats_clr", 32'(ERR_TIMEOUT), 32'd1);
    @(posedge clk); #1;
    chk("t4_err_cleared", 32'(ERR_TIMEOUT), 32'd0);
    ERR_CLR = 1'b0;
    wait_idle(20, "t4_done");
    chk("t4_none_delivered", 32'(got_q.size() - base), 32'd0);
    chk("t4_level", 32'(FIFO_LEVEL), 32'd0);

    // Asynchronous reset mid-handshake with three buffered events
    map_mode = 1'b0;
    for (int k = 0; k < 4; k++) load(0, 12'(12'h200 + k), 10'(k));
    n = 0;
    while (!(FIFO_LEVEL == 4'd3 && SRC_ACK[0]) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_pre_req", 32'(MAP_IN_AERIN_REQ), 32'd1);
    chk("t6_pre_level", 32'(FIFO_LEVEL), 32'd3);
    chk("t6_pre_ack", 32'(SRC_ACK), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_req", 32'(MAP_IN_AERIN_REQ), 32'd0);
    chk("t6_ack", 32'(SRC_ACK), 32'd0);
    chk("t6_level", 32'(FIFO_LEVEL), 32'd0);
    chk("t6_busy", 32'(BUSY), 32'd0);
    drv_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) src_wr[s] = src_rd[s];
    rst = 1'b0;
    base = got_q.size();
    map_mode = 1'b1;
    drv_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_lost", 32'(got_q.size() - base), 32'd0);
    chk("t6_idle", 32'(BUSY), 32'd0);

    chk("one_hot_ack", 32'(multi_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aer_map_event_scheduler.md
Name: aer_map_event_scheduler

Overview:
- Arbitrates N_SRC upstream AER producers onto the single AER input of the local-receptive-field mapper.
- Captures one event per 4-phase handshake under round-robin grant and buffers it in a small FIFO.
- Replays each buffered event to the mapper with a 4-phase REQ/ACK handshake, guarded by a timeout.
- Sits between the spike routers/aggregators and the mapper; every mapper input event passes through it.

Parameters:
- N_SRC, 4, number of upstream AER sources (≥2).
- AER_WIDTH, 12, event word width; bits [AER_WIDTH-1 -: 2] are event_type.
- FIFO_DEPTH, 8, buffered events (power of 2, ≥2).
- TIMEOUT, 255, max cycles waiting for MAP_IN_AERIN_ACK rise.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- SRC_REQ  in  N_SRC  per-source request.
- SRC_EVENT  in  N_SRC×AER_WIDTH  per-source event word.
- SRC_IDX  in  N_SRC×(AER_WIDTH-2)  per-source index {c,y,x}.
- SRC_ACK  out  N_SRC  per-source acknowledge.
- MAP_IN_AERIN_REQ  out  1  request to mapper.
- MAP_IN_AERIN_EVENT  out  AER_WIDTH  event to mapper.
- MAP_IN_AERIN_IDX  out  AER_WIDTH-2  index to mapper.
- MAP_IN_AERIN_ACK  in  1  mapper acknowledge (all hit cores acked).
- ERR_CLR  in  1  clears ERR_TIMEOUT.
- ERR_TIMEOUT  out  1  sticky timeout flag.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  occupancy.
- DROP_CNT  out  CNT_W  count of dropped invalid events.
- BUSY  out  1  FIFO non-empty or either FSM not idle.

Behaviour:
- Reset:
  - All outputs 0; FIFO empty; round-robin pointer = 0; both FSMs idle.
  - Reset mid-handshake aborts immediately; the buffered event and any in-flight event are lost.
- Input FSM, states IN_IDLE and IN_ACK:
  - IN_IDLE: grant = first asserted SRC_REQ at or after the rr pointer (wrapping).
  - On grant, if FIFO not full: register SRC_ACK[g]=1, push {EVENT,IDX}, set rr = g+1 mod N_SRC, go to IN_ACK.
  - IN_ACK: hold ACK until SRC_REQ[g]=0, then clear ACK and return to IN_IDLE. Re-arbitration is possible on the following edge.
  - FIFO full: no grant, no ACK; requests wait.
  - event_type==2'b11 (invalid): handshake completes normally, but the event is not pushed and DROP_CNT increments, saturating at all-ones.
  - At most one SRC_ACK is high at any time.
- Output FSM, states OUT_IDLE, OUT_REQ, OUT_REL:
  - OUT_IDLE: if FIFO non-empty, drive head on EVENT/IDX, set REQ=1, clear the timer, go to OUT_REQ.
  - OUT_REQ: on ACK=1, set REQ=0 and go to OUT_REL. Otherwise increment the timer.
  - Timer reaching TIMEOUT: REQ=0, pop and discard the head, set ERR_TIMEOUT=1, go to OUT_REL.
  - OUT_REL: when ACK=0, pop the head (unless already discarded) and go to OUT_IDLE.
  - EVENT/IDX stay stable from the REQ rise until the REQ fall.
- Latency:
  - SRC_REQ sampled high at edge t → SRC_ACK high after edge t.
  - MAP_IN_AERIN_REQ rises after edge t+1 when the FIFO was empty.
  - Minimum 3 cycles per output event with a combinationally fast ACK.
- FIFO:
  - Push and pop in the same cycle allowed; level unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - FIFO_LEVEL is exact, 0..FIFO_DEPTH.
- Order: FIFO order = grant order. Broadcast event types (01/10) are not reordered relative to neural events (00).
- ERR_TIMEOUT:
  - Cleared by ERR_CLR or rst.
  - A set condition and ERR_CLR in the same cycle leaves it set.

Test Plan:
1. Single source 0 sends EVENT=0x005, IDX=0x05; mapper ACKs 1 cycle after REQ → SRC_ACK[0] one cycle after REQ; MAP_IN_AERIN_REQ two cycles after; MAP_IN_AERIN_EVENT=0x005; FIFO_LEVEL returns to 0.
2. All 4 sources request continuously from reset, 3 events each → output source order 0,1,2,3,0,1,2,3,…; 12 events delivered; never two SRC_ACK high together.
3. Mapper ACK held low: 8 events accepted, FIFO_LEVEL=8 → 9th source request not acknowledged until the first pop; no event lost.
4. Mapper never ACKs with TIMEOUT=255 → REQ falls exactly 255 cycles after rising; ERR_TIMEOUT=1; head discarded; next event issued; ERR_CLR clears the flag.
5. Source sends event_type 2'b11 → SRC_ACK completes, no MAP_IN_AERIN_REQ, DROP_CNT=1; a following 2'b01 broadcast is delivered unchanged.
6. rst asserted while in OUT_REQ with FIFO_LEVEL=3 → MAP_IN_AERIN_REQ and all SRC_ACK fall immediately (asynchronously); FIFO_LEVEL=0, BUSY=0.
